// File: rtl/threshold_cutter_pkg.sv
// Shared constants, parser state type and square-sum width helper for threshold_cutter.
// No logic, so no latency or backpressure of its own.
package threshold_cutter_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'h55;
    localparam logic [7:0] ACC_TYPE    = 8'h51;

    // Byte positions inside an 11-byte sensor package
    localparam int IDX_TYPE      = 1;
    localparam int IDX_PAY_FIRST = 2;
    localparam int IDX_PAY_LAST  = 9;
    localparam int IDX_CSUM      = 10;
    localparam int PAY_BYTES     = IDX_PAY_LAST - IDX_PAY_FIRST + 1;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } parse_state_t;

    // Three squares of a signed src_w value cannot overflow 2*src_w+2 bits
    function automatic int sq_sum_width(input int src_w);
        return 2 * src_w + 2;
    endfunction

endpackage

// File: rtl/threshold_cutter_sqsum.sv
// Sum of squares of three signed axis values; purely combinational.
// Zero latency, no handshake.
module threshold_cutter_sqsum
    import threshold_cutter_pkg::*;
#(
    parameter int SRC_W = 16,
    parameter int SUM_W = sq_sum_width(SRC_W)
) (
    input  logic signed [SRC_W-1:0] i_ax,
    input  logic signed [SRC_W-1:0] i_ay,
    input  logic signed [SRC_W-1:0] i_az,
    output logic        [SUM_W-1:0] o_sum
);

    localparam int SQ_W = 2 * SRC_W;

    logic signed [SQ_W-1:0] w_sq_x;
    logic signed [SQ_W-1:0] w_sq_y;
    logic signed [SQ_W-1:0] w_sq_z;

    assign w_sq_x = i_ax * i_ax;
    assign w_sq_y = i_ay * i_ay;
    assign w_sq_z = i_az * i_az;

    // A square is never negative, so zero-extension keeps its value
    assign o_sum = SUM_W'(unsigned'(w_sq_x))
                 + SUM_W'(unsigned'(w_sq_y))
                 + SUM_W'(unsigned'(w_sq_z));

endmodule

// File: rtl/threshold_cutter.sv
// Frames IMU packages, packs PACKAGE_NUM good payloads per window into a circular buffer with a per-slot threshold flag.
// Commit one edge after the last checksum byte; read data one edge after rd_en_i; no backpressure, old slots overwritten.
module threshold_cutter
    import threshold_cutter_pkg::*;
#(
    parameter int          WINDOW_DEPTH_INDEX    = 7,
    parameter int          WINDOW_DEPTH          = 100,
    parameter int          WINDOW_WIDTH          = 256,
    parameter logic [31:0] THRESHOLD             = 32'h0010_0000,
    parameter int          A_OFFSET              = 2,
    parameter int          SQUARE_SRC_DATA_WIDTH = 16,
    parameter int          PACKAGE_SIZE          = 11,
    parameter int          PACKAGE_NUM           = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_i,
    input  logic                          byte_valid_i,
    input  logic                          rd_en_i,
    input  logic [WINDOW_DEPTH_INDEX-1:0] rd_addr_i,
    output logic [WINDOW_WIDTH-1:0]       rd_data_o,
    output logic [WINDOW_DEPTH-1:0]       flag_o,
    output logic [WINDOW_DEPTH_INDEX-1:0] wr_ptr_o,
    output logic                          win_done_o
);

    localparam int PKG_BITS   = PAY_BYTES * 8;
    localparam int PAY_IDX_W  = $clog2(PAY_BYTES);
    localparam int BYTE_CNT_W = $clog2(PACKAGE_SIZE);
    localparam int PKG_CNT_W  = (PACKAGE_NUM > 1) ? $clog2(PACKAGE_NUM) : 1;
    localparam int SRC_W      = SQUARE_SRC_DATA_WIDTH;
    localparam int SUM_W      = sq_sum_width(SRC_W);
    localparam int A_LSB      = (A_OFFSET - IDX_PAY_FIRST) * 8;
    localparam int IDX_W      = WINDOW_DEPTH_INDEX;

    parse_state_t r_state;
    parse_state_t w_state_nxt;

    logic [BYTE_CNT_W-1:0]                r_byte_cnt;
    logic [7:0]                           r_csum;
    logic [7:0]                           r_type;
    logic [PAY_BYTES-1:0][7:0]            r_pay;
    logic [PACKAGE_NUM-1:0][PKG_BITS-1:0] r_asm;
    logic [PKG_CNT_W-1:0]                 r_pkg_cnt;
    logic                                 r_pend;
    logic                                 r_commit;
    logic [IDX_W-1:0]                     r_wr_ptr;
    logic [WINDOW_DEPTH-1:0]              r_flag;
    logic [WINDOW_WIDTH-1:0]              r_rd_data;
    logic [WINDOW_WIDTH-1:0]              r_mem [WINDOW_DEPTH];

    logic                 w_csum_byte;
    logic                 w_pkg_good;
    logic                 w_last_pkg;
    logic                 w_hit;
    logic                 w_rd_in_range;
    logic [PKG_BITS-1:0]  w_pay_flat;
    logic [PAY_IDX_W-1:0] w_pay_idx;
    logic [SUM_W-1:0]     w_sum;

    assign w_csum_byte   = (r_state == ST_COLLECT) && (r_byte_cnt == BYTE_CNT_W'(IDX_CSUM));
    assign w_pay_idx     = PAY_IDX_W'(r_byte_cnt - BYTE_CNT_W'(IDX_PAY_FIRST));
    assign w_pay_flat    = r_pay;
    assign w_last_pkg    = (r_pkg_cnt == PKG_CNT_W'(PACKAGE_NUM - 1));
    assign w_rd_in_range = int'(rd_addr_i) < WINDOW_DEPTH;

    // ------------------------------------------------------------------
    // Package parser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pkg_good  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (byte_valid_i && (byte_i == HEADER_BYTE)) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (byte_valid_i && w_csum_byte) begin
                    w_state_nxt = ST_HUNT;
                    w_pkg_good  = (byte_i == r_csum);
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_type     <= '0;
            r_pay      <= '0;
        end else if (byte_valid_i) begin
            if (r_state == ST_HUNT) begin
                if (byte_i == HEADER_BYTE) begin
                    r_byte_cnt <= BYTE_CNT_W'(IDX_TYPE);
                    r_csum     <= HEADER_BYTE;
                end
            end else if (w_csum_byte) begin
                r_byte_cnt <= '0;
            end else begin
                r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
                r_csum     <= r_csum + byte_i;
                if (r_byte_cnt == BYTE_CNT_W'(IDX_TYPE)) begin
                    r_type <= byte_i;
                end else begin
                    r_pay[w_pay_idx] <= byte_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Acceleration magnitude check on the completed payload
    // ------------------------------------------------------------------
    threshold_cutter_sqsum #(
        .SRC_W (SRC_W),
        .SUM_W (SUM_W)
    ) u_sqsum (
        .i_ax  ($signed(w_pay_flat[A_LSB         +: SRC_W])),
        .i_ay  ($signed(w_pay_flat[A_LSB + SRC_W   +: SRC_W])),
        .i_az  ($signed(w_pay_flat[A_LSB + 2*SRC_W +: SRC_W])),
        .o_sum (w_sum)
    );

    assign w_hit = (r_type == ACC_TYPE) && (w_sum > SUM_W'(THRESHOLD));

    // ------------------------------------------------------------------
    // Window assembly and commit
    // ------------------------------------------------------------------
    // A good package never lands in the commit cycle: one spans 11 byte cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm     <= '0;
            r_pkg_cnt <= '0;
            r_pend    <= 1'b0;
            r_commit  <= 1'b0;
            r_wr_ptr  <= '0;
            r_flag    <= '0;
        end else if (r_commit) begin
            r_commit         <= 1'b0;
            r_asm            <= '0;
            r_pkg_cnt        <= '0;
            r_pend           <= 1'b0;
            r_flag[r_wr_ptr] <= r_pend;
            r_wr_ptr         <= (r_wr_ptr == IDX_W'(WINDOW_DEPTH - 1)) ? '0
                                                                      : r_wr_ptr + IDX_W'(1);
        end else if (w_pkg_good) begin
            r_asm[r_pkg_cnt] <= w_pay_flat;
            if (w_hit) begin
                r_pend <= 1'b1;
            end
            if (w_last_pkg) begin
                r_commit <= 1'b1;
            end else begin
                r_pkg_cnt <= r_pkg_cnt + PKG_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window buffer: one write port, one registered read-first port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_commit) begin
            r_mem[r_wr_ptr] <= r_asm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en_i) begin
            r_rd_data <= w_rd_in_range ? r_mem[rd_addr_i] : '0;
        end
    end

    assign rd_data_o  = r_rd_data;
    assign flag_o     = r_flag;
    assign wr_ptr_o   = r_wr_ptr;
    assign win_done_o = r_commit;

endmodule

// File: tb/tb_threshold_cutter.sv
// Bench for threshold_cutter: scoreboard of expected windows, one task per scenario.
// Commits are checked by a monitor; window contents via the read port.
module tb_threshold_cutter;

    localparam int IDX   = 7;
    localparam int DEPTH = 100;
    localparam int WW    = 256;
    localparam int NPKG  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       byte_i;
    logic             byte_valid_i;
    logic             rd_en_i;
    logic [IDX-1:0]   rd_addr_i;
    logic [WW-1:0]    rd_data_o;
    logic [DEPTH-1:0] flag_o;
    logic [IDX-1:0]   wr_ptr_o;
    logic             win_done_o;

    threshold_cutter dut (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .flag_o       (flag_o),
        .wr_ptr_o     (wr_ptr_o),
        .win_done_o   (win_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            slot;
        logic [WW-1:0] data;
        bit            flag;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    int            n_commits = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [WW-1:0] model_mem [DEPTH];
    bit            model_flag [DEPTH];
    logic [WW-1:0] asm_m;
    int            pcnt_m;
    bit            pend_m;
    int            wr_ptr_m;

    function automatic bit over_thresh(input logic [63:0] p);
        longint ax, ay, az, s;
        ax = longint'($signed(p[15:0]));
        ay = longint'($signed(p[31:16]));
        az = longint'($signed(p[47:32]));
        s  = ax * ax + ay * ay + az * az;
        return s > longint'(32'h0010_0000);
    endfunction

    function automatic logic [63:0] acc_pay(input logic [15:0] ax, input logic [15:0] ay,
                                           input logic [15:0] az, input logic [15:0] ex);
        return {ex, az, ay, ax};
    endfunction

    function automatic logic [15:0] rnd_axis();
        int m;
        m = $urandom_range(0, 1400);
        return ($urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
    endfunction

    // Commit monitor: checks slot, flag and pointer advance against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (win_done_o === 1'b1) begin
                n_commits++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_commit: wr_ptr_o=%0d, required no commit", wr_ptr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (wr_ptr_o !== IDX'(mon_e.slot)) begin
                        bad++;
                        $display("FAIL commit_slot: got %0d required %0d", wr_ptr_o, mon_e.slot);
                    end
                    @(negedge clk);
                    total++;
                    if (flag_o[mon_e.slot] !== mon_e.flag) begin
                        bad++;
                        $display("FAIL commit_flag: slot %0d got %b required %b",
                                 mon_e.slot, flag_o[mon_e.slot], mon_e.flag);
                    end
                    total++;
                    if (wr_ptr_o !== IDX'((mon_e.slot + 1) % DEPTH)) begin
                        bad++;
                        $display("FAIL wr_ptr_advance: got %0d required %0d",
                                 wr_ptr_o, (mon_e.slot + 1) % DEPTH);
                    end
                    total++;
                    if (win_done_o !== 1'b0) begin
                        bad++;
                        $display("FAIL win_done_width: got %b required 0", win_done_o);
                    end
                    model_mem[mon_e.slot]  = mon_e.data;
                    model_flag[mon_e.slot] = mon_e.flag;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_i       = b;
        byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
    endtask

    task automatic send_pkg(input logic [7:0] typ, input logic [63:0] pay,
                            input bit corrupt, input int gap);
        logic [7:0] cs;
        exp_t       e;
        cs = 8'h55 + typ;
        for (int i = 0; i < 8; i++) cs = cs + pay[8*i +: 8];
        if (corrupt) cs = cs + 8'h01;
        if (!corrupt) begin
            asm_m[64*pcnt_m +: 64] = pay;
            if (typ == 8'h51 && over_thresh(pay)) pend_m = 1'b1;
            pcnt_m++;
            if (pcnt_m == NPKG) begin
                e.slot = wr_ptr_m;
                e.data = asm_m;
                e.flag = pend_m;
                exp_q.push_back(e);
                wr_ptr_m = (wr_ptr_m + 1) % DEPTH;
                asm_m    = '0;
                pend_m   = 1'b0;
                pcnt_m   = 0;
            end
        end
        send_byte(8'h55);
        idle(gap);
        send_byte(typ);
        idle(gap);
        for (int i = 0; i < 8; i++) begin
            send_byte(pay[8*i +: 8]);
            idle(gap);
        end
        send_byte(cs);
    endtask

    task automatic read_slot(input logic [IDX-1:0] a, output logic [WW-1:0] d);
        rd_en_i   = 1'b1;
        rd_addr_i = a;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
        d       = rd_data_o;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        byte_valid_i = 1'b0;
        rd_en_i      = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        asm_m    = '0;
        pcnt_m   = 0;
        pend_m   = 1'b0;
        wr_ptr_m = 0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model_flag[i] = 1'b0;
    endtask

    task automatic wait_commits();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL commit_timeout: %0d windows pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        rd_en_i      = 1'b0;
        rd_addr_i    = '0;
        asm_m = '0; pcnt_m = 0; pend_m = 1'b0; wr_ptr_m = 0;
        #3;
        idle(2);
        total++;
        if (wr_ptr_o !== '0) begin bad++; $display("FAIL reset_wr_ptr: got %0d required 0", wr_ptr_o); end
        total++;
        if (flag_o !== '0) begin bad++; $display("FAIL reset_flag: got %h required 0", flag_o); end
        total++;
        if (win_done_o !== 1'b0) begin bad++; $display("FAIL reset_win_done: got %b required 0", win_done_o); end
        total++;
        if (rd_data_o !== '0) begin bad++; $display("FAIL reset_rd_data: got %h required 0", rd_data_o); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_threshold_equal();
        int c0;
        do_reset();
        c0 = n_commits;
        send_pkg(8'h51, acc_pay(16'h0400, 16'h0000, 16'h0000, 16'h0000), 1'b0, 0);
        for (int i = 0; i < 3; i++) send_pkg(8'h51, 64'h0, 1'b0, 0);
        wait_commits();
        total++;
        if (n_commits - c0 !== 1) begin bad++; $display("FAIL eq_commit_count: got %0d required 1", n_commits - c0); end
        total++;
        if (flag_o[0] !== 1'b0) begin bad++; $display("FAIL eq_flag0: got %b required 0", flag_o[0]); end
        total++;
        if (wr_ptr_o !== IDX'(1)) begin bad++; $display("FAIL eq_wr_ptr: got %0d required 1", wr_ptr_o); end
    endtask

    task automatic test_threshold_above();
        logic [WW-1:0] d;
        do_reset();
        send_pkg(8'h51, acc_pay(16'h0401, 16'h0000, 16'h0000, 16'h0000), 1'b0, 0);
        for (int i = 0; i < 3; i++) send_pkg(8'h51, 64'h0, 1'b0, 0);
        wait_commits();
        total++;
        if (flag_o[0] !== 1'b1) begin bad++; $display("FAIL above_flag0: got %b required 1", flag_o[0]); end
        read_slot('0, d);
        total++;
        if (d[15:0] !== 16'h0401) begin bad++; $display("FAIL above_ax: got %h required 0401", d[15:0]); end
        total++;
        if (d !== model_mem[0]) begin bad++; $display("FAIL above_window: got %h required %h", d, model_mem[0]); end
        rd_addr_i = IDX'(5);
        idle(3);
        total++;
        if (rd_data_o !== model_mem[0]) begin bad++; $display("FAIL read_hold: got %h required %h", rd_data_o, model_mem[0]); end
    endtask

    task automatic test_bad_checksum();
        int c0;
        logic [WW-1:0] d;
        do_reset();
        c0 = n_commits;
        send_pkg(8'h51, acc_pay(16'h0400, 16'h0000, 16'h0000, 16'h0000), 1'b1, 0);
        send_pkg(8'h52, 64'h1111_2222_3333_4444, 1'b0, 0);
        send_pkg(8'h52, 64'h5555_6666_7777_8888, 1'b0, 0);
        send_pkg(8'h51, acc_pay(16'h0010, 16'hFFF0, 16'h0020, 16'hABCD), 1'b0, 0);
        idle(5);
        total++;
        if (n_commits !== c0) begin bad++; $display("FAIL badcs_early_commit: got %0d commits required 0", n_commits - c0); end
        total++;
        if (wr_ptr_o !== '0) begin bad++; $display("FAIL badcs_wr_ptr: got %0d required 0", wr_ptr_o); end
        send_pkg(8'h52, 64'h0102_0304_0506_0708, 1'b0, 0);
        wait_commits();
        total++;
        if (n_commits - c0 !== 1) begin bad++; $display("FAIL badcs_commit_count: got %0d required 1", n_commits - c0); end
        read_slot('0, d);
        total++;
        if (d !== model_mem[0]) begin bad++; $display("FAIL badcs_window: got %h required %h", d, model_mem[0]); end
    endtask

    task automatic test_noise_and_type();
        logic [WW-1:0] d;
        logic [63:0]   big;
        do_reset();
        big = acc_pay(16'h8000, 16'h8000, 16'h8000, 16'hFFFF);
        send_byte(8'h12);
        send_byte(8'h34);
        send_pkg(8'h53, big, 1'b0, 1);
        send_byte(8'h77);
        for (int i = 0; i < 3; i++)
            send_pkg(8'h51, acc_pay(16'h0010, 16'hFFE0, 16'h0030, 16'(i)), 1'b0, 0);
        wait_commits();
        total++;
        if (flag_o[0] !== 1'b0) begin bad++; $display("FAIL noise_flag0: got %b required 0", flag_o[0]); end
        read_slot('0, d);
        total++;
        if (d[63:0] !== big) begin bad++; $display("FAIL noise_type53_payload: got %h required %h", d[63:0], big); end
        total++;
        if (d !== model_mem[0]) begin bad++; $display("FAIL noise_window: got %h required %h", d, model_mem[0]); end
    endtask

    task automatic test_wrap();
        logic [WW-1:0]    d;
        logic [DEPTH-1:0] ef;
        do_reset();
        send_pkg(8'h51, acc_pay(16'h8000, 16'h8000, 16'h8000, 16'h0000), 1'b0, 0);
        for (int i = 0; i < 3; i++) send_pkg(8'h52, {$urandom, $urandom}, 1'b0, 0);
        wait_commits();
        total++;
        if (flag_o[0] !== 1'b1) begin bad++; $display("FAIL wrap_first_flag0: got %b required 1", flag_o[0]); end
        for (int w = 1; w < DEPTH; w++) begin
            for (int p = 0; p < NPKG; p++) begin
                if ($urandom_range(0, 1) == 1)
                    send_pkg(8'h51, acc_pay(rnd_axis(), rnd_axis(), rnd_axis(), 16'($urandom)),
                             1'b0, $urandom_range(0, 1));
                else
                    send_pkg(8'h52, {$urandom, $urandom}, 1'b0, 0);
            end
        end
        wait_commits();
        total++;
        if (wr_ptr_o !== '0) begin bad++; $display("FAIL wrap_ptr_zero: got %0d required 0", wr_ptr_o); end
        for (int p = 0; p < NPKG; p++) send_pkg(8'h52, {$urandom, $urandom}, 1'b0, 0);
        wait_commits();
        total++;
        if (wr_ptr_o !== IDX'(1)) begin bad++; $display("FAIL wrap_ptr_one: got %0d required 1", wr_ptr_o); end
        total++;
        if (flag_o[0] !== 1'b0) begin bad++; $display("FAIL wrap_flag0_overwrite: got %b required 0", flag_o[0]); end
        for (int i = 0; i < DEPTH; i++) ef[i] = model_flag[i];
        total++;
        if (flag_o !== ef) begin bad++; $display("FAIL wrap_all_flags: got %h required %h", flag_o, ef); end
        read_slot('0, d);
        total++;
        if (d !== model_mem[0]) begin bad++; $display("FAIL wrap_slot0: got %h required %h", d, model_mem[0]); end
        read_slot(IDX'(DEPTH - 1), d);
        total++;
        if (d !== model_mem[DEPTH-1]) begin bad++; $display("FAIL wrap_slot99: got %h required %h", d, model_mem[DEPTH-1]); end
        read_slot(IDX'(DEPTH), d);
        total++;
        if (d !== '0) begin bad++; $display("FAIL read_out_of_range_100: got %h required 0", d); end
        read_slot(IDX'(127), d);
        total++;
        if (d !== '0) begin bad++; $display("FAIL read_out_of_range_127: got %h required 0", d); end
    endtask

    task automatic test_reset_mid_and_collision();
        int            c0;
        logic [WW-1:0] d;
        logic [WW-1:0] old0;
        do_reset();
        send_pkg(8'h52, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 0);
        send_pkg(8'h52, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 0);
        send_byte(8'h55);
        send_byte(8'h51);
        send_byte(8'h01);
        do_reset();
        c0   = n_commits;
        old0 = model_mem[0];
        for (int i = 0; i < 3; i++) send_pkg(8'h52, {32'h0A0B_0C00 + i, 32'h1000_0000 + i}, 1'b0, 0);
        send_pkg(8'h51, acc_pay(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b0, 0);
        read_slot('0, d);
        total++;
        if (d !== old0) begin bad++; $display("FAIL collision_read_first: got %h required %h", d, old0); end
        wait_commits();
        total++;
        if (n_commits - c0 !== 1) begin bad++; $display("FAIL rst_commit_count: got %0d required 1", n_commits - c0); end
        read_slot('0, d);
        total++;
        if (d !== model_mem[0]) begin bad++; $display("FAIL rst_post_window: got %h required %h", d, model_mem[0]); end
    endtask

    initial begin
        test_reset();
        test_threshold_equal();
        test_threshold_above();
        test_bad_checksum();
        test_noise_and_type();
        test_wrap();
        test_reset_mid_and_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/threshold_cutter.md
Name: threshold_cutter

Overview:
Streaming core of the motion-capture path. It takes the byte stream received from the IMU over the serial link, frames and checks 11-byte sensor packages, and packs the payloads of PACKAGE_NUM good packages into one WINDOW_WIDTH-bit window. Windows go into a circular buffer of WINDOW_DEPTH entries. Each slot has a flag that marks whether any acceleration package in that window had squared magnitude above THRESHOLD. Downstream logic reads windows through a simple synchronous read port.

Parameters:
WINDOW_DEPTH_INDEX 7 — address width of the window buffer.
WINDOW_DEPTH 100 — number of window slots; must be <= 2**WINDOW_DEPTH_INDEX.
WINDOW_WIDTH 256 — bits per window; equals PACKAGE_NUM*8*8.
THRESHOLD 32'h0010_0000 — squared-magnitude cut level; comparison is strict (>).
A_OFFSET 2 — byte index of AxL inside a package.
SQUARE_SRC_DATA_WIDTH 16 — signed width of each acceleration axis.
PACKAGE_SIZE 11 — bytes per package.
PACKAGE_NUM 4 — good packages per window.

Ports:
clk input 1 — single clock, rising edge.
rst input 1 — asynchronous, active-high reset.
byte_i input 8 — received serial byte.
byte_valid_i input 1 — byte_i is valid this cycle; one byte per pulse.
rd_en_i input 1 — read request.
rd_addr_i input WINDOW_DEPTH_INDEX — window slot to read.
rd_data_o output WINDOW_WIDTH — read data; valid one cycle after rd_en_i.
flag_o output WINDOW_DEPTH — per-slot threshold flag.
wr_ptr_o output WINDOW_DEPTH_INDEX — next slot to be written.
win_done_o output 1 — one-cycle pulse when a window is committed.

Behaviour:
- Reset (async, rst=1): parser goes to HUNT; byte counter, package counter, window assembly register, pending flag, wr_ptr_o, flag_o, rd_data_o and win_done_o all clear to 0. Buffer contents are not cleared.
- Package format: byte0 = 0x55 (header), byte1 = type, bytes2..9 = payload, byte10 = checksum. The checksum is the sum of bytes 0..9 mod 256.
- Parser state machine:
  - HUNT: ignore bytes until 0x55, then go to COLLECT with count = 1.
  - COLLECT: store each byte. On byte 10, compare the checksum.
  - On checksum mismatch: discard the package and return to HUNT. Package counter and window assembly are unchanged.
  - On checksum match: go to HUNT and process the package as good.
- Processing a good package:
  - Payload bytes 2..9 go into the window assembly at slot pkg_cnt. Package k occupies bits [64k+63:64k], with byte2 in the least significant byte.
  - If type == 0x51: Ax, Ay and Az are signed 16-bit little-endian values at A_OFFSET, A_OFFSET+2 and A_OFFSET+4.
  - sum = Ax² + Ay² + Az², computed as unsigned 2*SQUARE_SRC_DATA_WIDTH+2 = 34 bits with no overflow. -32768² = 2^30.
  - If sum > THRESHOLD, set the pending flag.
  - Other type values only contribute payload.
- Window commit: when the good package is number PACKAGE_NUM, the commit happens on the clock edge after the checksum byte is accepted. On that edge:
  - mem[wr_ptr] is written with the full assembly (including the last package).
  - flag_o[wr_ptr] takes the pending flag (including the last package's contribution). This overwrites the old flag.
  - wr_ptr increments, wrapping from WINDOW_DEPTH-1 to 0.
  - win_done_o is high for exactly that one cycle.
  - Package counter, assembly and pending flag clear.
  - Old slots are overwritten silently; no overflow indication.
- Read port: when rd_en_i=1, rd_data_o is registered from mem[rd_addr_i] on the next edge and holds otherwise. If a read and a commit target the same slot in the same cycle, the read returns the old contents (read-first). rd_addr_i >= WINDOW_DEPTH returns 0.
- A byte_valid_i in the commit cycle is accepted normally by the parser.
- Reset mid-package or mid-window discards partial data.

Decomposition:
- Shared package threshold_cutter_pkg holds:
  - HEADER_BYTE = 8'h55 and ACC_TYPE = 8'h51;
  - the package byte-index constants;
  - the square-sum width function.
- One sub-module, threshold_cutter_sqsum: three signed squarers plus adder, purely combinational, 34-bit output.
- The window buffer is an inferred simple dual-port RAM inside the top.

Test Plan:
1. Four good 0x51 packages, all axes 0 except package0 Ax=0x0400 (sum = 0x0010_0000, equals THRESHOLD) -> win_done_o pulses once, flag_o[0]=0, wr_ptr_o=1.
2. Same as 1 but Ax=0x0401 (sum 0x0010_0801) -> flag_o[0]=1. Reading addr 0 returns rd_data_o[15:0]=0x0401 next cycle.
3. Package 55 51 00 04 00 00 00 00 00 00 with checksum 0xAB (correct 0xAA) -> package dropped, no commit after three more good packages, window completes only on the fourth good one.
4. Noise bytes 0x12 0x34 before 0x55 and a 0x53-type package -> noise ignored; 0x53 payload stored, flag unaffected even with huge values.
5. Commit WINDOW_DEPTH+1 windows, slot0 first flagged then unflagged -> wr_ptr_o wraps to 1, flag_o[0]=0, slot0 holds newest data.
6. Assert rst after 2 good packages, then send 4 -> exactly one commit containing only post-reset packages. Read/commit collision on same slot returns old data.
